// File: rtl/fust_s_scoreboard_pkg.sv
// Shared types for the scalar scoreboard: FU enumeration, status-row layout and tag encoding.
package fust_s_scoreboard_pkg;

    localparam int NUM_FU_S = 3;
    localparam int REG_W    = 5;
    localparam int FU_S_W   = 2;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        FU_ALU    = 2'd0,
        FU_LDST   = 2'd1,
        FU_BRANCH = 2'd2
    } fu_scalar_t;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [FU_S_W-1:0] fu_tag_t;

    typedef struct packed {
        logic     busy;
        reg_idx_t r;
        reg_idx_t r1;
        reg_idx_t r2;
        fu_tag_t  t1;
        fu_tag_t  t2;
    } fust_s_row_t;

    typedef struct packed {
        fust_s_row_t [NUM_FU_S-1:0] op;
    } fust_s_t;

    // Tag 0 means "value is in the register file"; FU f produces tag f+1.
    function automatic fu_tag_t fu_tag(input logic [1:0] idx);
        return fu_tag_t'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/fust_s_regstat.sv
// Register result-status table: which FU tag will produce each register,
// with writeback bypass on operand lookup and owner-checked clear.
module fust_s_regstat
    import fust_s_scoreboard_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  reg_idx_t lk_rs1,
    input  reg_idx_t lk_rs2,
    input  reg_idx_t lk_rd,
    input  logic     wb_fire,
    input  fu_tag_t  wb_tag,
    input  reg_idx_t clr_rd,
    input  logic     set_en,
    input  reg_idx_t set_rd,
    input  fu_tag_t  set_tag,
    output fu_tag_t  t1,
    output fu_tag_t  t2,
    output fu_tag_t  rd_tag
);

    fu_tag_t [NUM_REGS-1:0] regstat_q;
    fu_tag_t [NUM_REGS-1:0] regstat_d;

    function automatic fu_tag_t lookup(input fu_tag_t [NUM_REGS-1:0] tbl, input reg_idx_t rs,
                                       input logic byp, input fu_tag_t byp_tag);
        fu_tag_t t;
        t = (rs == '0) ? '0 : tbl[rs];
        if (byp && t == byp_tag) t = '0;
        return t;
    endfunction

    // WAW check deliberately sees only registered state, no bypass.
    assign rd_tag = regstat_q[lk_rd];

    always_comb begin
        t1 = lookup(regstat_q, lk_rs1, wb_fire, wb_tag);
        t2 = lookup(regstat_q, lk_rs2, wb_fire, wb_tag);
    end

    always_comb begin
        regstat_d = regstat_q;
        // A newer producer may already own clr_rd; only the recorded owner may release it.
        if (wb_fire && regstat_q[clr_rd] == wb_tag) regstat_d[clr_rd] = '0;
        if (set_en && set_rd != '0) regstat_d[set_rd] = set_tag;
    end

    // NOTE: this table is reset, unlike a data RAM: a stale tag would stall dispatch forever.
    always_ff @(posedge CLK) begin
        if (RST) regstat_q <= '0;
        // NOTE: sequential state is always assigned non-blocking.
        else     regstat_q <= regstat_d;
    end

endmodule

// File: rtl/fust_s_scoreboard.sv
// Scalar-side scoreboard: FU status rows, dispatch/issue/writeback handshakes,
// and dependency wakeup between the ALU, LD_ST and BRANCH units.
module fust_s_scoreboard
    import fust_s_scoreboard_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [1:0]                disp_fu,
    input  logic [REG_W-1:0]          disp_rd,
    input  logic [REG_W-1:0]          disp_rs1,
    input  logic [REG_W-1:0]          disp_rs2,
    output logic [NUM_FU_S-1:0]       issue_valid,
    input  logic [NUM_FU_S-1:0]       issue_ready,
    output logic [NUM_FU_S*REG_W-1:0] issue_rs1,
    output logic [NUM_FU_S*REG_W-1:0] issue_rs2,
    output logic [NUM_FU_S*REG_W-1:0] issue_rd,
    input  logic                      wb_valid,
    input  logic [1:0]                wb_fu,
    output logic                      wb_ready,
    output fust_s_t                   fust_out
);

    fust_s_row_t [NUM_FU_S-1:0] row_q, row_d;
    logic [NUM_FU_S-1:0]        issued_q, issued_d;

    logic       disp_fu_ok, wb_fu_ok, disp_fire, wb_fire, wb_row_ok, war;
    logic [1:0] disp_idx, wb_idx;
    fu_tag_t    t1_lk, t2_lk, rd_tag;

    assign disp_fu_ok = int'(disp_fu) < NUM_FU_S;
    assign wb_fu_ok   = int'(wb_fu) < NUM_FU_S;
    assign disp_idx   = disp_fu_ok ? disp_fu : 2'd0;
    assign wb_idx     = wb_fu_ok ? wb_fu : 2'd0;

    always_comb begin
        disp_ready = disp_fu_ok && !row_q[disp_idx].busy && (disp_rd == '0 || rd_tag == '0);
        disp_fire  = disp_valid && disp_ready;
    end

    always_comb begin
        wb_row_ok = wb_fu_ok && row_q[wb_idx].busy && issued_q[wb_idx];
        war       = 1'b0;
        for (int g = 0; g < NUM_FU_S; g++) begin
            if (g != int'(wb_idx) && row_q[g].busy && !issued_q[g] && row_q[wb_idx].r != '0 &&
                ((row_q[g].r1 == row_q[wb_idx].r && row_q[g].t1 == '0) ||
                 (row_q[g].r2 == row_q[wb_idx].r && row_q[g].t2 == '0)))
                war = 1'b1;
        end
        // Idle ready is high; a request for an idle or unissued FU is refused and ignored.
        wb_ready = wb_row_ok ? !war : !wb_valid;
        wb_fire  = wb_valid && wb_ready;
    end

    always_comb begin
        issue_valid = '0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        issue_rd    = '0;
        for (int f = 0; f < NUM_FU_S; f++) begin
            issue_valid[f]               = row_q[f].busy && !issued_q[f] &&
                                           row_q[f].t1 == '0 && row_q[f].t2 == '0;
            issue_rs1[f*REG_W +: REG_W]  = row_q[f].r1;
            issue_rs2[f*REG_W +: REG_W]  = row_q[f].r2;
            issue_rd[f*REG_W +: REG_W]   = row_q[f].r;
        end
    end

    fust_s_regstat u_regstat (
        .CLK     (CLK),
        .RST     (RST),
        .lk_rs1  (disp_rs1),
        .lk_rs2  (disp_rs2),
        .lk_rd   (disp_rd),
        .wb_fire (wb_fire),
        .wb_tag  (fu_tag(wb_idx)),
        .clr_rd  (row_q[wb_idx].r),
        .set_en  (disp_fire),
        .set_rd  (disp_rd),
        .set_tag (fu_tag(disp_idx)),
        .t1      (t1_lk),
        .t2      (t2_lk),
        .rd_tag  (rd_tag)
    );

    always_comb begin
        row_d    = row_q;
        issued_d = issued_q;
        for (int f = 0; f < NUM_FU_S; f++) begin
            if (issue_valid[f] && issue_ready[f]) issued_d[f] = 1'b1;
            if (wb_fire && row_q[f].t1 == fu_tag(wb_idx)) row_d[f].t1 = '0;
            if (wb_fire && row_q[f].t2 == fu_tag(wb_idx)) row_d[f].t2 = '0;
        end
        if (wb_fire) begin
            row_d[wb_idx].busy = 1'b0;
            issued_d[wb_idx]   = 1'b0;
        end
        // disp_ready uses registered busy, so this never lands on the row being written back.
        if (disp_fire) begin
            row_d[disp_idx].busy = 1'b1;
            row_d[disp_idx].r    = disp_rd;
            row_d[disp_idx].r1   = disp_rs1;
            row_d[disp_idx].r2   = disp_rs2;
            row_d[disp_idx].t1   = t1_lk;
            row_d[disp_idx].t2   = t2_lk;
            issued_d[disp_idx]   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            row_q    <= '0;
            issued_q <= '0;
        end else begin
            row_q    <= row_d;
            issued_q <= issued_d;
        end
    end

    assign fust_out.op = row_q;

endmodule
